// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
package prog_loader_pkg;

    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = ADDR_W + 1;
    localparam int HDR_MIN = 1;
    localparam int HDR_MAX = DEPTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_loader.sv
// Loads a framed byte stream (length, payload, checksum) into CPU memory
// and releases the CPU only when the checksum matches.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    prog_loader_if.slave      stream,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_start,
    output logic              cpu_run
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              hdr_ok;
    logic              last_byte;
    logic              sum_ok;

    assign stream.in_ready = !reset &&
                             (state == IDLE || state == LOAD || state == CHECK);
    assign accept    = stream.in_valid && stream.in_ready;
    assign hdr_ok    = (stream.in_data >= DATA_W'(HDR_MIN)) &&
                       (stream.in_data <= DATA_W'(HDR_MAX));
    assign last_byte = (count + CNT_W'(1)) == len;
    assign sum_ok    = stream.in_data == sum;

    assign busy    = (state == LOAD) || (state == CHECK);
    assign cpu_run = (state == DONE);

    always_ff @(posedge clock) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = hdr_ok ? LOAD : ERR;
            LOAD:     if (accept && last_byte) state_nxt = CHECK;
            CHECK:    if (accept) state_nxt = sum_ok ? DONE : ERR;
            DONE, ERR: if (load_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: header latch, payload writes, running checksum, status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            len       <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_start <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            if (accept) begin
                unique case (state)
                    IDLE: begin
                        len   <= stream.in_data[CNT_W-1:0];
                        count <= '0;
                        sum   <= '0;
                        done  <= 1'b0;
                        error <= !hdr_ok;
                    end
                    LOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count[ADDR_W-1:0];
                        mem_wdata <= stream.in_data;
                        sum       <= sum + stream.in_data;
                        count     <= count + CNT_W'(1);
                    end
                    CHECK: begin
                        done      <= sum_ok;
                        error     <= !sum_ok;
                        cpu_start <= sum_ok;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
